fifo_wr_frontend: RTL and testbench
===================================

FIFO_WR_FRONTEND -- requirements
Module: fifo_wr_frontend

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the write data path.
REQ-002 Parameter PTR_WIDTH, default 4: gray pointer width; FIFO depth is 2^(PTR_WIDTH-1) = 8.
REQ-003 Parameter AFULL_THRESH, default 6: occupancy at or above which w_almost_full asserts.
REQ-004 The block SHALL have port w_clk  input  1  write-domain clock, rising edge.
REQ-005 The block SHALL have port w_rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port s_data  input  DATA_WIDTH  producer data.
REQ-007 The block SHALL have port s_valid  input  1  producer data valid.
REQ-008 The block SHALL have port s_ready  output  1  block can accept a beat.
REQ-009 The block SHALL have port w_full  input  1  FIFO-full flag from the write-pointer block.
REQ-010 The block SHALL have port wptr_gray  input  PTR_WIDTH  gray write pointer from the write-pointer block.
REQ-011 The block SHALL have port rptr_gray_async  input  PTR_WIDTH  gray read pointer from the read clock domain.
REQ-012 The block SHALL have port rptr_sync  output  PTR_WIDTH  read pointer synchronized to w_clk, which feeds the write-pointer block.
REQ-013 The block SHALL have port w_en  output  1  write request to the write-pointer block.
REQ-014 The block SHALL have port w_data  output  DATA_WIDTH  data for the FIFO memory write port.
REQ-015 The block SHALL have port w_level  output  PTR_WIDTH  registered FIFO occupancy, range 0..8.
REQ-016 The block SHALL have port w_almost_full  output  1  registered flag: w_level >= AFULL_THRESH.

Function
REQ-017 The block SHALL use a 2-entry skid buffer (head, tail) with a registered count of 0, 1 or 2.
REQ-018 A beat SHALL be accepted when s_valid && s_ready at the rising edge of w_clk.
REQ-019 A beat SHALL be popped when w_en && !w_full at the rising edge of w_clk.
REQ-020 s_ready SHALL equal (count != 2), decoded only from the registered count and never from s_valid or w_full.
REQ-021 w_en SHALL equal (count != 0), and w_data SHALL equal the head entry.
REQ-022 Latency SHALL be one cycle: a beat accepted at edge N asserts w_en with its data after edge N when the buffer was empty.
REQ-023 Data SHALL be written to the FIFO in acceptance order, with no loss and no duplication.
REQ-024 A push with no pop SHALL increment count, and the new beat SHALL be stored at the head if count was 0, otherwise at the tail.
REQ-025 A pop with no push SHALL decrement count and move the tail to the head.
REQ-026 A simultaneous push and pop at count 1 SHALL leave count at 1 with the new beat at the head.
REQ-027 A simultaneous push and pop at count 2 cannot occur, because s_ready is low.
REQ-028 When w_full is held high, w_en and w_data SHALL hold stable until the pop occurs.
REQ-029 rptr_sync SHALL be a two-flop synchronizer of rptr_gray_async with no logic between the stages, giving 2 w_clk edges of latency.
REQ-030 w_level SHALL be registered as gray2bin(wptr_gray) - gray2bin(rptr_sync), computed modulo 2^PTR_WIDTH.
REQ-031 The w_level computation SHALL handle pointer wrap-around correctly, for example wptr bin 1 and rptr bin 13 give level 4.
REQ-032 w_almost_full SHALL be registered from the same next-level value, so it changes in the same cycle as w_level.
REQ-033 The block SHALL NOT modify w_full and SHALL NOT qualify w_en with w_full internally.

Reset
REQ-034 On w_rst low the block SHALL asynchronously clear count, head, tail, both synchronizer stages, w_level and w_almost_full to 0.
REQ-035 During reset the outputs SHALL be s_ready=1, w_en=0, w_data=0 and rptr_sync=0.
REQ-036 Reset mid-transfer SHALL discard buffered beats with no write issued.
REQ-037 Deassertion of reset SHALL be synchronous to w_clk, via an external reset synchronizer.

Verification
REQ-038 Scenario, single beat: s_data=0xA5 with s_valid pulsed for 1 cycle, w_full=0 -> w_en=1 and w_data=0xA5 for exactly 1 cycle starting the next cycle; count returns to 0.
REQ-039 Scenario, back-pressure: w_full=1 while beats 0x11, 0x22, 0x33 are offered -> 0x11 and 0x22 are accepted and s_ready goes 0; after w_full=0, writes occur in order 0x11, 0x22, then 0x33.
REQ-040 Scenario, streaming: s_valid=1 continuously with w_full=0 -> one write per cycle and s_ready stays 1.
REQ-041 Scenario, synchronizer: rptr_gray_async changes 0000->0001 -> rptr_sync shows 0001 after exactly 2 edges.
REQ-042 Scenario, level and wrap: wptr_gray=bin2gray(1) and rptr_sync settled at bin2gray(13) -> w_level=4 and w_almost_full=0; wptr bin 7 and rptr bin 0 -> w_level=7 and w_almost_full=1.
REQ-043 Scenario, reset mid-operation: assert w_rst with count=2 -> w_en=0 and s_ready=1 immediately; no write occurs after release until a new beat is accepted.

Source files
------------

// File: rtl/fifo_wr_frontend.sv
// Write-side front end of an async FIFO: 2-entry skid buffer toward the write-pointer
// block, read-pointer synchronizer, and registered occupancy / almost-full flag.
module fifo_wr_frontend #(
   parameter int DATA_WIDTH   = 8,
   parameter int PTR_WIDTH    = 4,
   parameter int AFULL_THRESH = 6
) (
   input  logic                  w_clk,
   input  logic                  w_rst,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  w_full,
   input  logic [PTR_WIDTH-1:0]  wptr_gray,
   input  logic [PTR_WIDTH-1:0]  rptr_gray_async,
   output logic [PTR_WIDTH-1:0]  rptr_sync,
   output logic                  w_en,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic [PTR_WIDTH-1:0]  w_level,
   output logic                  w_almost_full
);

   function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
      logic [PTR_WIDTH-1:0] b;
      b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
      for (int i = PTR_WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [1:0]            count;
   logic [DATA_WIDTH-1:0] head, tail;
   logic [PTR_WIDTH-1:0]  rptr_meta, rptr_q;
   logic [PTR_WIDTH-1:0]  next_level;
   logic                  push, pop;

   // Handshake decodes come only from registered count, so no comb path s_valid/w_full -> s_ready.
   assign s_ready = (count != 2'd2);
   assign w_en    = (count != 2'd0);
   assign w_data  = head;
   assign push    = s_valid && s_ready;
   assign pop     = w_en && !w_full;

   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= s_data;
               else               tail <= s_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            // Push and pop together is only possible at count 1: new beat replaces head.
            2'b11: head <= s_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         rptr_meta <= '0;
         rptr_q    <= '0;
      end else begin
         rptr_meta <= rptr_gray_async;
         rptr_q    <= rptr_meta;
      end
   end

   assign rptr_sync = rptr_q;

   // Modulo subtraction handles pointer wrap for free.
   assign next_level = gray2bin(wptr_gray) - gray2bin(rptr_q);

   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         w_level       <= '0;
         w_almost_full <= 1'b0;
      end else begin
         w_level       <= next_level;
         w_almost_full <= (next_level >= PTR_WIDTH'(AFULL_THRESH));
      end
   end

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Directed, table-driven bench for fifo_wr_frontend: skid buffer handshake, write
// order, synchronizer latency, occupancy with wrap, and reset behaviour.
module tb_fifo_wr_frontend;

   logic       w_clk = 1'b0;
   logic       w_rst = 1'b0;
   logic [7:0] s_data = '0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic       w_full = 1'b0;
   logic [3:0] wptr_gray = '0;
   logic [3:0] rptr_gray_async = '0;
   logic [3:0] rptr_sync;
   logic       w_en;
   logic [7:0] w_data;
   logic [3:0] w_level;
   logic       w_almost_full;

   int checks = 0;
   int errors = 0;
   logic [7:0] wr_log[$];

   always #5 w_clk = ~w_clk;

   fifo_wr_frontend #(.DATA_WIDTH(8), .PTR_WIDTH(4), .AFULL_THRESH(6)) dut (
      .w_clk(w_clk), .w_rst(w_rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .w_full(w_full), .wptr_gray(wptr_gray), .rptr_gray_async(rptr_gray_async),
      .rptr_sync(rptr_sync), .w_en(w_en), .w_data(w_data), .w_level(w_level),
      .w_almost_full(w_almost_full)
   );

   // Every write the FIFO would actually take.
   always @(posedge w_clk) if (w_rst && w_en && !w_full) wr_log.push_back(w_data);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       f;
      logic       rdy;
      logic       wen;
      logic [7:0] wd;
      logic       cd;   // compare w_data on this row
   } vec_t;

   typedef struct {
      logic [3:0] wg;
      logic [3:0] rg;
      logic [3:0] lvl;
      logic       af;
   } lvl_t;

   vec_t vecs[13];
   lvl_t lvls[6];
   logic [7:0] exp_log[8];

   initial begin
      // single beat
      vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
      // back-pressure
      vecs[2]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1};
      vecs[3]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1};
      vecs[4]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1};
      vecs[5]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
      vecs[6]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1};
      vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
      // streaming
      vecs[8]  = '{1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1};
      vecs[9]  = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1};
      vecs[10] = '{1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 8'h42, 1'b1};
      vecs[11] = '{1'b1, 8'h43, 1'b0, 1'b1, 1'b1, 8'h43, 1'b1};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};

      exp_log = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43};

      // gray codes: bin1=0001 bin13=1011 bin7=0100 bin0=0000 bin6=0101 bin5=0111
      //             bin2=0011 bin12=1010 bin8=1100
      lvls[0] = '{4'b0001, 4'b1011, 4'd4, 1'b0};
      lvls[1] = '{4'b0100, 4'b0000, 4'd7, 1'b1};
      lvls[2] = '{4'b0101, 4'b0000, 4'd6, 1'b1};
      lvls[3] = '{4'b0111, 4'b0000, 4'd5, 1'b0};
      lvls[4] = '{4'b0011, 4'b1010, 4'd6, 1'b1};
      lvls[5] = '{4'b1100, 4'b0000, 4'd8, 1'b1};

      // reset state, with a nonzero async pointer that must not leak through
      rptr_gray_async = 4'b1011;
      repeat (3) @(posedge w_clk);
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_w_en", 32'(w_en), 32'd0);
      chk("rst_w_data", 32'(w_data), 32'd0);
      chk("rst_rptr_sync", 32'(rptr_sync), 32'd0);
      chk("rst_w_level", 32'(w_level), 32'd0);
      chk("rst_afull", 32'(w_almost_full), 32'd0);
      @(negedge w_clk);
      rptr_gray_async = 4'b0000;
      w_rst = 1'b1;
      repeat (2) @(posedge w_clk);

      // synchronizer latency
      @(negedge w_clk);
      rptr_gray_async = 4'b0001;
      @(posedge w_clk); #1;
      chk("sync_edge1", 32'(rptr_sync), 32'd0);
      @(posedge w_clk); #1;
      chk("sync_edge2", 32'(rptr_sync), 32'd1);

      // occupancy and wrap
      for (int i = 0; i < 6; i++) begin
         @(negedge w_clk);
         wptr_gray = lvls[i].wg;
         rptr_gray_async = lvls[i].rg;
         repeat (3) @(posedge w_clk);
         #1;
         chk($sformatf("level_%0d", i), 32'(w_level), 32'(lvls[i].lvl));
         chk($sformatf("afull_%0d", i), 32'(w_almost_full), 32'(lvls[i].af));
      end
      @(negedge w_clk);
      wptr_gray = '0;
      rptr_gray_async = '0;

      // skid buffer vectors
      for (int i = 0; i < 13; i++) begin
         @(negedge w_clk);
         s_valid = vecs[i].v;
         s_data  = vecs[i].d;
         w_full  = vecs[i].f;
         @(posedge w_clk); #1;
         chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].rdy));
         chk($sformatf("v%0d_w_en", i), 32'(w_en), 32'(vecs[i].wen));
         if (vecs[i].cd) chk($sformatf("v%0d_w_data", i), 32'(w_data), 32'(vecs[i].wd));
      end

      chk("log_size", 32'(wr_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < wr_log.size(); i++)
         chk($sformatf("log_%0d", i), 32'(wr_log[i]), 32'(exp_log[i]));

      // reset mid-operation with two beats buffered
      @(negedge w_clk);
      w_full = 1'b1; s_valid = 1'b1; s_data = 8'h77;
      @(posedge w_clk);
      @(negedge w_clk);
      s_data = 8'h88;
      @(posedge w_clk); #1;
      chk("pre_rst_s_ready", 32'(s_ready), 32'd0);
      chk("pre_rst_w_data", 32'(w_data), 32'h77);
      #2;
      w_rst = 1'b0;
      #1;
      chk("midrst_w_en", 32'(w_en), 32'd0);
      chk("midrst_s_ready", 32'(s_ready), 32'd1);
      chk("midrst_w_data", 32'(w_data), 32'd0);
      @(negedge w_clk);
      s_valid = 1'b0; w_full = 1'b0;
      w_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge w_clk); #1;
         chk($sformatf("post_rst_w_en_%0d", i), 32'(w_en), 32'd0);
      end
      chk("post_rst_log", 32'(wr_log.size()), 32'd8);

      // a fresh beat after reset is written normally
      @(negedge w_clk);
      s_valid = 1'b1; s_data = 8'h5C;
      @(posedge w_clk); #1;
      chk("fresh_w_en", 32'(w_en), 32'd1);
      chk("fresh_w_data", 32'(w_data), 32'h5C);
      @(negedge w_clk);
      s_valid = 1'b0;
      @(posedge w_clk); #1;
      chk("fresh_done", 32'(w_en), 32'd0);
      chk("fresh_log", 32'(wr_log.size()), 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
